// File: rtl/rob_pkg.sv
// Shared definitions for the multi-writeback, dual-commit reorder buffer.
// This package holds the instruction kinds, default widths and the commit slot count.
package rob_pkg;

  typedef enum logic [1:0] {
    KIND_ALU = 2'd0,
    KIND_BR  = 2'd1,
    KIND_ST  = 2'd2,
    KIND_LD  = 2'd3
  } kind_e;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_NWB    = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int CM_SLOTS   = 2;

  // Only register-writing, non-control-flow, non-store kinds may retire in pairs.
  function automatic logic kind_pairable(input logic [1:0] kind);
    return (kind == KIND_ALU) || (kind == KIND_LD);
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup port. It compares a tag against the stored ready bit and against every writeback channel.
// A writeback hit overrides the stored value, and the highest-numbered channel wins.
module rob_query_port #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NWB    = 2,
  parameter int DATA_W = 32
) (
  input  logic [IDX_W-1:0]      q_idx_in,
  input  logic [DEPTH-1:0]      ready_vec_in,
  input  logic [DATA_W-1:0]     stored_data_in,
  input  logic [NWB-1:0]        wb_en_in,
  input  logic [NWB*IDX_W-1:0]  wb_idx_in,
  input  logic [NWB*DATA_W-1:0] wb_data_in,
  output logic                  ready_out,
  output logic [DATA_W-1:0]     data_out
);

  always_comb begin
    ready_out = ready_vec_in[q_idx_in];
    data_out  = stored_data_in;
    for (int k = 0; k < NWB; k++) begin
      if (wb_en_in[k] && (wb_idx_in[k*IDX_W +: IDX_W] == q_idx_in)) begin
        ready_out = 1'b1;
        data_out  = wb_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Circular reorder buffer with NWB writeback channels, bypassed operand lookups and dual-slot in-order commit.
// Control state resets asynchronously; the entry payload arrays are not reset, because ready_q gates them.
module rob_multi
  import rob_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NWB    = DEF_NWB,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       alloc_en_in,
  input  logic [REG_W-1:0]           alloc_rd_in,
  input  logic [ADDR_W-1:0]          alloc_pc_in,
  input  logic                       alloc_bp_in,
  input  logic [1:0]                 alloc_kind_in,
  output logic [IDX_W-1:0]           alloc_idx_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [IDX_W:0]             count_out,
  input  logic [NWB-1:0]             wb_en_in,
  input  logic [NWB*IDX_W-1:0]       wb_idx_in,
  input  logic [NWB*DATA_W-1:0]      wb_data_in,
  input  logic [NWB-1:0]             wb_jump_en_in,
  input  logic [NWB*ADDR_W-1:0]      wb_jump_a_in,
  input  logic [2*IDX_W-1:0]         q_idx_in,
  output logic [1:0]                 q_ready_out,
  output logic [2*DATA_W-1:0]        q_data_out,
  output logic [CM_SLOTS-1:0]        cm_en_out,
  output logic [CM_SLOTS*IDX_W-1:0]  cm_idx_out,
  output logic [CM_SLOTS*REG_W-1:0]  cm_rd_out,
  output logic [CM_SLOTS*DATA_W-1:0] cm_data_out,
  output logic [CM_SLOTS*ADDR_W-1:0] cm_pc_out,
  output logic [CM_SLOTS-1:0]        cm_jump_en_out,
  output logic [CM_SLOTS*ADDR_W-1:0] cm_jump_a_out,
  output logic [CM_SLOTS-1:0]        cm_bp_out,
  output logic [CM_SLOTS*2-1:0]      cm_kind_out,
  input  logic                       flush_in
);

  logic [IDX_W:0]      head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [DEPTH-1:0]    ready_q, ready_d;

  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic [REG_W-1:0]    rd_q   [DEPTH];
  logic [REG_W-1:0]    rd_d   [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];
  logic [ADDR_W-1:0]   pc_d   [DEPTH];
  logic [ADDR_W-1:0]   ja_q   [DEPTH];
  logic [ADDR_W-1:0]   ja_d   [DEPTH];
  logic [1:0]          kind_q [DEPTH];
  logic [1:0]          kind_d [DEPTH];
  logic [DEPTH-1:0]    bp_q, bp_d, jen_q, jen_d;

  logic [CM_SLOTS-1:0]        cm_en_q, cm_en_d, cm_jen_q, cm_jen_d, cm_bp_q, cm_bp_d;
  logic [CM_SLOTS*IDX_W-1:0]  cm_idx_q, cm_idx_d;
  logic [CM_SLOTS*REG_W-1:0]  cm_rd_q, cm_rd_d;
  logic [CM_SLOTS*DATA_W-1:0] cm_data_q, cm_data_d;
  logic [CM_SLOTS*ADDR_W-1:0] cm_pc_q, cm_pc_d, cm_ja_q, cm_ja_d;
  logic [CM_SLOTS*2-1:0]      cm_kind_q, cm_kind_d;

  logic [IDX_W-1:0] head_tag, head1_tag, tail_tag, wb_tag;
  logic             fire0, fire1, alloc_acc;

  // A tag is live when its distance from head, taken modulo DEPTH, is below the occupancy.
  function automatic logic tag_live(input logic [IDX_W-1:0] tag, input logic [IDX_W-1:0] head,
                                    input logic [IDX_W:0] count);
    logic [IDX_W-1:0] offset;
    offset = tag - head;
    return {1'b0, offset} < count;
  endfunction

  assign head_tag  = head_q[IDX_W-1:0];
  assign head1_tag = head_tag + IDX_W'(1);
  assign tail_tag  = tail_q[IDX_W-1:0];

  assign full_out      = (count_q == (IDX_W+1)'(DEPTH));
  assign empty_out     = (count_q == '0);
  assign count_out     = count_q;
  assign alloc_idx_out = tail_tag;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ready_d   = ready_q;
    data_d    = data_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    ja_d      = ja_q;
    kind_d    = kind_q;
    bp_d      = bp_q;
    jen_d     = jen_q;
    cm_en_d   = cm_en_q;
    cm_idx_d  = cm_idx_q;
    cm_rd_d   = cm_rd_q;
    cm_data_d = cm_data_q;
    cm_pc_d   = cm_pc_q;
    cm_jen_d  = cm_jen_q;
    cm_ja_d   = cm_ja_q;
    cm_bp_d   = cm_bp_q;
    cm_kind_d = cm_kind_q;
    fire0     = 1'b0;
    fire1     = 1'b0;
    alloc_acc = 1'b0;
    wb_tag    = '0;

    if (rdy_in) begin
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        ready_d = '0;
        cm_en_d = '0;
      end else begin
        fire0 = (count_q != '0) && ready_q[head_tag];
        fire1 = fire0 && (count_q >= (IDX_W+1)'(2)) && ready_q[head1_tag] &&
                kind_pairable(kind_q[head_tag]) && kind_pairable(kind_q[head1_tag]);
        cm_en_d = {fire1, fire0};
        if (fire0) begin
          cm_idx_d[0 +: IDX_W]   = head_tag;
          cm_rd_d[0 +: REG_W]    = rd_q[head_tag];
          cm_data_d[0 +: DATA_W] = data_q[head_tag];
          cm_pc_d[0 +: ADDR_W]   = pc_q[head_tag];
          cm_jen_d[0]            = jen_q[head_tag];
          cm_ja_d[0 +: ADDR_W]   = ja_q[head_tag];
          cm_bp_d[0]             = bp_q[head_tag];
          cm_kind_d[0 +: 2]      = kind_q[head_tag];
        end
        if (fire1) begin
          cm_idx_d[IDX_W +: IDX_W]    = head1_tag;
          cm_rd_d[REG_W +: REG_W]     = rd_q[head1_tag];
          cm_data_d[DATA_W +: DATA_W] = data_q[head1_tag];
          cm_pc_d[ADDR_W +: ADDR_W]   = pc_q[head1_tag];
          cm_jen_d[1]                 = jen_q[head1_tag];
          cm_ja_d[ADDR_W +: ADDR_W]   = ja_q[head1_tag];
          cm_bp_d[1]                  = bp_q[head1_tag];
          cm_kind_d[2 +: 2]           = kind_q[head1_tag];
        end

        // Full is judged on pre-edge occupancy, so a same-edge commit cannot make room.
        alloc_acc = alloc_en_in && !full_out;
        if (alloc_acc) begin
          ready_d[tail_tag] = 1'b0;
          rd_d[tail_tag]    = alloc_rd_in;
          pc_d[tail_tag]    = alloc_pc_in;
          bp_d[tail_tag]    = alloc_bp_in;
          kind_d[tail_tag]  = alloc_kind_in;
        end

        for (int k = 0; k < NWB; k++) begin
          wb_tag = wb_idx_in[k*IDX_W +: IDX_W];
          if (wb_en_in[k] && tag_live(wb_tag, head_tag, count_q)) begin
            ready_d[wb_tag] = 1'b1;
            data_d[wb_tag]  = wb_data_in[k*DATA_W +: DATA_W];
            jen_d[wb_tag]   = wb_jump_en_in[k];
            ja_d[wb_tag]    = wb_jump_a_in[k*ADDR_W +: ADDR_W];
          end
        end

        head_d  = head_q + (IDX_W+1)'(fire0) + (IDX_W+1)'(fire1);
        tail_d  = tail_q + (IDX_W+1)'(alloc_acc);
        count_d = count_q + (IDX_W+1)'(alloc_acc) - (IDX_W+1)'(fire0) - (IDX_W+1)'(fire1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ready_q   <= '0;
      cm_en_q   <= '0;
      cm_idx_q  <= '0;
      cm_rd_q   <= '0;
      cm_data_q <= '0;
      cm_pc_q   <= '0;
      cm_jen_q  <= '0;
      cm_ja_q   <= '0;
      cm_bp_q   <= '0;
      cm_kind_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      cm_en_q   <= cm_en_d;
      cm_idx_q  <= cm_idx_d;
      cm_rd_q   <= cm_rd_d;
      cm_data_q <= cm_data_d;
      cm_pc_q   <= cm_pc_d;
      cm_jen_q  <= cm_jen_d;
      cm_ja_q   <= cm_ja_d;
      cm_bp_q   <= cm_bp_d;
      cm_kind_q <= cm_kind_d;
    end
  end

  always_ff @(posedge clk_in) begin
    data_q <= data_d;
    rd_q   <= rd_d;
    pc_q   <= pc_d;
    ja_q   <= ja_d;
    kind_q <= kind_d;
    bp_q   <= bp_d;
    jen_q  <= jen_d;
  end

  assign cm_en_out      = cm_en_q;
  assign cm_idx_out     = cm_idx_q;
  assign cm_rd_out      = cm_rd_q;
  assign cm_data_out    = cm_data_q;
  assign cm_pc_out      = cm_pc_q;
  assign cm_jump_en_out = cm_jen_q;
  assign cm_jump_a_out  = cm_ja_q;
  assign cm_bp_out      = cm_bp_q;
  assign cm_kind_out    = cm_kind_q;

  for (genvar p = 0; p < 2; p++) begin : g_query
    rob_query_port #(
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .NWB    (NWB),
      .DATA_W (DATA_W)
    ) u_query (
      .q_idx_in       (q_idx_in[p*IDX_W +: IDX_W]),
      .ready_vec_in   (ready_q),
      .stored_data_in (data_q[q_idx_in[p*IDX_W +: IDX_W]]),
      .wb_en_in       (wb_en_in),
      .wb_idx_in      (wb_idx_in),
      .wb_data_in     (wb_data_in),
      .ready_out      (q_ready_out[p]),
      .data_out       (q_data_out[p*DATA_W +: DATA_W])
    );
  end

endmodule
